mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory between the multi-cycle core and an external loader/debug port. It sits between the core's memory interface (address from the adrsrc mux, memwrite, write data) and the memory macro. It serialises accesses with round-robin fairness, a req/ack handshake to each requester, and a watchdog that aborts hung memory transactions. While an access is outstanding, the core's control FSM holds its current state (c_req high, c_ack low).

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the core and an external port.
// A watchdog aborts memory transactions that never acknowledge.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_ack,
  output logic [DW-1:0] e_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          err,
  output logic          owner
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_C = 2'd1;
  localparam logic [1:0] BUSY_E = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          c_elig;
  logic          e_elig;
  logic          pick_e;
  logic          finish;
  logic [DW-1:0] rd_result;

  // A port still high in its own ack cycle must not be granted again.
  assign c_elig = c_req & ~c_ack;
  assign e_elig = e_req & ~e_ack;
  assign pick_e = e_elig & (~c_elig | ~owner);

  assign finish    = m_ack | (cnt == CNT_LAST);
  assign rd_result = m_ack ? m_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b1;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      c_ack   <= 1'b0;
      e_ack   <= 1'b0;
      err     <= 1'b0;
      c_rdata <= '0;
      e_rdata <= '0;
    end else begin
      c_ack <= 1'b0;
      e_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (c_elig || e_elig) begin
            state   <= pick_e ? BUSY_E : BUSY_C;
            owner   <= pick_e;
            m_req   <= 1'b1;
            m_we    <= pick_e ? e_we : c_we;
            m_addr  <= pick_e ? e_addr : c_addr;
            m_wdata <= pick_e ? e_wdata : c_wdata;
            cnt     <= '0;
          end
        end
        BUSY_C, BUSY_E: begin
          // m_ack in the last watchdog cycle wins over the abort.
          if (finish) begin
            state <= IDLE;
            m_req <= 1'b0;
            err   <= ~m_ack;
            if (state == BUSY_E) begin
              e_ack <= 1'b1;
              if (!m_we) e_rdata <= rd_result;
            end else begin
              c_ack <= 1'b1;
              if (!m_we) c_rdata <= rd_result;
            end
          end else begin
            // Never reaches past CNT_LAST, so the counter cannot wrap.
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand-written corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_ack, e_req, e_we, e_ack;
  logic [AW-1:0] c_addr, e_addr, m_addr;
  logic [DW-1:0] c_wdata, e_wdata, c_rdata, e_rdata, m_wdata, m_rdata;
  logic          m_req, m_we, m_ack, err, owner;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_rdata(e_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err), .owner(owner)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // memory responder: acks in m_req cycle index 'lat' (0 = first cycle)
  int          lat = 0;
  logic [31:0] rsp_data = 32'h0;
  logic        stray = 1'b0;
  int          mcyc = 0;
  logic        mreq_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (m_req) mcyc = mreq_prev ? mcyc + 1 : 0;
    mreq_prev = m_req;
    m_ack   = (m_req && mcyc == lat) || stray;
    m_rdata = (m_req && mcyc == lat) ? rsp_data : 32'hBAD0_0000;
  endtask

  // results of one transaction
  int          r_winner, r_delay, r_errcnt, r_mreq;
  logic        r_err, r_held, r_pulse;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic        r_we;

  task automatic do_txn(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                        input int l, input logic [31:0] rd);
    logic first;
    lat = l; rsp_data = rd;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    e_req = er; e_we = ew; e_addr = ea; e_wdata = ed;
    r_winner = -1; r_delay = -1; r_errcnt = 0; r_mreq = 0; r_held = 1'b1;
    r_err = 1'b0; r_rdata = '0; r_addr = '0; r_wdata = '0; r_we = 1'b0;
    first = 1'b1;
    for (int i = 1; i <= TIMEOUT + 8; i++) begin
      cycle();
      if (err) r_errcnt++;
      if (m_req) begin
        if (first) begin
          r_addr = m_addr; r_we = m_we; r_wdata = m_wdata; first = 1'b0;
        end else if (m_addr !== r_addr || m_we !== r_we || m_wdata !== r_wdata) begin
          r_held = 1'b0;
        end
        r_mreq++;
      end
      if (c_ack || e_ack) begin
        r_winner = (c_ack && e_ack) ? 2 : (e_ack ? 1 : 0);
        r_delay  = i;
        r_err    = err;
        r_rdata  = e_ack ? e_rdata : c_rdata;
        break;
      end
    end
    c_req = 1'b0; e_req = 1'b0;
    cycle();
    r_pulse = !(c_ack || e_ack);
    if (err) r_errcnt++;
  endtask

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic er, ew; logic [31:0] ea, ed;
    int lat; logic [31:0] rd;
    int win; int dly; logic xerr; logic [31:0] xrdata; logic [31:0] xaddr;
  } vec_t;

  vec_t vt[9];

  int          m_owner;
  logic [31:0] m_rd[2];

  initial begin
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    m_ack = 0; m_rdata = 0;
    rst = 1'b1;

    //        cr cw ca     cd        er ew ea      ed          lat rd            win dly err rdata         addr
    vt[0] = '{1, 0, 32'h40, 0,        0, 0, 0,      0,          0,  32'hDEADBEEF, 0, 2,  0, 32'hDEADBEEF, 32'h40};
    vt[1] = '{1, 0, 32'h44, 0,        1, 0, 32'h200, 0,         1,  32'hA5A50001, 1, 3,  0, 32'hA5A50001, 32'h200};
    vt[2] = '{1, 0, 32'h48, 0,        1, 0, 32'h204, 0,         0,  32'h11112222, 0, 2,  0, 32'h11112222, 32'h48};
    vt[3] = '{0, 0, 0,      0,        1, 1, 32'h100, 32'h12345678, 3, 32'hFFFFFFFF, 1, 5, 0, 32'hA5A50001, 32'h100};
    vt[4] = '{1, 0, 32'h80, 0,        0, 0, 0,      0,          15, 32'hCAFEF00D, 0, 17, 0, 32'hCAFEF00D, 32'h80};
    vt[5] = '{1, 0, 32'h84, 0,        0, 0, 0,      0,          16, 32'h00000055, 0, 17, 1, 32'h0,        32'h84};
    vt[6] = '{1, 1, 32'h88, 32'h77,   0, 0, 0,      0,          40, 32'h00000066, 0, 17, 1, 32'h0,        32'h88};
    vt[7] = '{1, 1, 32'h8C, 32'h99,   1, 0, 32'h300, 0,         2,  32'h0BADCAFE, 1, 4,  0, 32'h0BADCAFE, 32'h300};
    vt[8] = '{0, 0, 0,      0,        1, 0, 32'h304, 0,         0,  32'h13579BDF, 1, 2,  0, 32'h13579BDF, 32'h304};

    cycle(); cycle();
    rst = 1'b0;
    chk("rst_m_req", {31'b0, m_req}, 0);
    chk("rst_m_we", {31'b0, m_we}, 0);
    chk("rst_acks_err", {29'b0, c_ack, e_ack, err}, 0);
    chk("rst_owner", {31'b0, owner}, 1);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rdata", c_rdata | e_rdata, 0);
    cycle();

    // directed table
    for (int v = 0; v < 9; v++) begin
      do_txn(vt[v].cr, vt[v].cw, vt[v].ca, vt[v].cd, vt[v].er, vt[v].ew, vt[v].ea, vt[v].ed,
             vt[v].lat, vt[v].rd);
      chk($sformatf("v%0d_winner", v), r_winner, vt[v].win);
      chk($sformatf("v%0d_delay", v), r_delay, vt[v].dly);
      chk($sformatf("v%0d_err", v), {31'b0, r_err}, {31'b0, vt[v].xerr});
      chk($sformatf("v%0d_errcnt", v), r_errcnt, vt[v].xerr ? 1 : 0);
      chk($sformatf("v%0d_rdata", v), r_rdata, vt[v].xrdata);
      chk($sformatf("v%0d_m_addr", v), r_addr, vt[v].xaddr);
      chk($sformatf("v%0d_m_we", v), {31'b0, r_we}, {31'b0, (vt[v].win == 1) ? vt[v].ew : vt[v].cw});
      if (r_we) chk($sformatf("v%0d_m_wdata", v), r_wdata, (vt[v].win == 1) ? vt[v].ed : vt[v].cd);
      chk($sformatf("v%0d_mreq_cycles", v), r_mreq, ((vt[v].lat < TIMEOUT) ? vt[v].lat : TIMEOUT - 1) + 1);
      chk($sformatf("v%0d_payload_held", v), {31'b0, r_held}, 1);
      chk($sformatf("v%0d_ack_pulse", v), {31'b0, r_pulse}, 1);
    end

    // round robin with both ports held for three transactions each, from reset
    rst = 1'b1; #1; rst = 1'b0;
    cycle();
    begin
      int n = 0, nc = 0, ne = 0, last = 0;
      logic dbl = 1'b0;
      lat = 0; rsp_data = 32'h0;
      c_req = 1; c_we = 0; c_addr = 32'h10; e_req = 1; e_we = 0; e_addr = 32'h20;
      for (int i = 1; i <= 60 && n < 6; i++) begin
        cycle();
        if (c_ack && e_ack) dbl = 1'b1;
        if (c_ack || e_ack) begin
          n++;
          chk($sformatf("rr_order%0d", n), {31'b0, e_ack}, (n % 2 == 0) ? 1 : 0);
          if (n > 1) chk($sformatf("rr_gap%0d", n), i - last, 2);
          last = i;
          if (c_ack) nc++;
          if (e_ack) ne++;
          if (nc == 3) c_req = 0;
          if (ne == 3) e_req = 0;
        end
      end
      c_req = 0; e_req = 0;
      chk("rr_count", n, 6);
      chk("rr_no_double", {31'b0, dbl}, 0);
      cycle();
    end

    // stray m_ack in IDLE, then payload change mid-busy
    begin
      logic bad = 1'b0;
      stray = 1'b1;
      for (int i = 0; i < 3; i++) begin
        cycle();
        if (c_ack || e_ack || err || m_req) bad = 1'b1;
      end
      stray = 1'b0;
      cycle();
      if (c_ack || e_ack || err) bad = 1'b1;
      chk("stray_ack_ignored", {31'b0, bad}, 0);
    end
    begin
      int got = 0;
      lat = 4; rsp_data = 32'h600DF00D;
      c_req = 1; c_we = 0; c_addr = 32'h400;
      cycle();
      chk("midbusy_addr_grant", m_addr, 32'h400);
      c_addr = 32'h999; c_we = 1;
      cycle(); cycle();
      chk("midbusy_addr_held", m_addr, 32'h400);
      chk("midbusy_we_held", {31'b0, m_we}, 0);
      for (int i = 0; i < 10 && got == 0; i++) begin
        cycle();
        if (c_ack) got = 1;
      end
      chk("midbusy_ack", got, 1);
      chk("midbusy_rdata", c_rdata, 32'h600DF00D);
      c_req = 0; c_we = 0;
      cycle();
    end

    // reset in the middle of an external access
    begin
      logic saw = 1'b0;
      lat = 100;
      e_req = 1; e_we = 0; e_addr = 32'h500;
      for (int i = 0; i < 5; i++) cycle();
      chk("pre_rst_m_req", {31'b0, m_req}, 1);
      rst = 1'b1;
      #1;
      chk("rst_async_m_req", {31'b0, m_req}, 0);
      chk("rst_async_owner", {31'b0, owner}, 1);
      e_req = 0;
      for (int i = 0; i < 2; i++) begin
        cycle();
        if (e_ack || err) saw = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cycle();
        if (e_ack || err) saw = 1'b1;
      end
      chk("rst_no_ack_err", {31'b0, saw}, 0);
      do_txn(1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 32'h0F0F0F0F);
      chk("post_rst_winner", r_winner, 0);
      chk("post_rst_delay", r_delay, 2);
      chk("post_rst_rdata", r_rdata, 32'h0F0F0F0F);
    end

    // randomized transactions against a transaction-level model
    rst = 1'b1; #1; rst = 1'b0;
    cycle();
    m_owner = 1; m_rd[0] = '0; m_rd[1] = '0;
    for (int t = 0; t < 150; t++) begin
      int mode, win, l, exp_dly;
      logic cw, ew, we, abort;
      logic [31:0] ca, cd, ea, ed, rd, exp_rd;
      mode = $urandom_range(0, 2);
      l = $urandom_range(0, TIMEOUT + 3);
      cw = 1'($urandom); ew = 1'($urandom);
      ca = $urandom; cd = $urandom; ea = $urandom; ed = $urandom; rd = $urandom;
      win = (mode == 2) ? ((m_owner == 1) ? 0 : 1) : mode;
      abort = (l >= TIMEOUT);
      we = (win == 1) ? ew : cw;
      exp_rd = we ? m_rd[win] : (abort ? 32'h0 : rd);
      exp_dly = (abort ? TIMEOUT - 1 : l) + 2;
      do_txn(mode != 1, cw, ca, cd, mode != 0, ew, ea, ed, l, rd);
      chk($sformatf("rnd%0d_winner", t), r_winner, win);
      chk($sformatf("rnd%0d_delay", t), r_delay, exp_dly);
      chk($sformatf("rnd%0d_err", t), r_errcnt, abort ? 1 : 0);
      chk($sformatf("rnd%0d_rdata", t), r_rdata, exp_rd);
      chk($sformatf("rnd%0d_m_addr", t), r_addr, (win == 1) ? ea : ca);
      m_rd[win] = exp_rd;
      m_owner = win;
      for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
